// File: rtl/io_pulse_monitor.sv
// io_pulse_monitor
//   Measures the single-bit io signal of the design under test. io_in is
//   synchronized, edges are detected, and the length of every completed
//   level phase (in clk cycles) is stored as a {level, width} record in a
//   small show-ahead FIFO drained through a valid/ready handshake.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst        asynchronous active-high reset
//   io_in      monitored signal, asynchronous to clk
//   en         measurement enable
//   m_valid    a record is available at the FIFO head
//   m_ready    consumer accepts the head record
//   m_level    level of the completed phase at the head (0 when empty)
//   m_width    phase length in clk cycles, saturating (0 when empty)
//   edge_count measured edges since the last enable, wraps
//   fifo_level number of stored records
//   overflow   sticky: a record was dropped because the FIFO was full
module io_pulse_monitor #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          io_in,
    input  logic                          en,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_level,
    output logic [CNT_W-1:0]              m_width,
    output logic [CNT_W-1:0]              edge_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [AW:0]      LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]      LVL_FULL = (AW+1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Synchronizer and edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   s;
    logic                   io_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], io_in};
            prev_q <= s;
        end
    end

    assign s       = sync_q[SYNC_STAGES-1];
    assign io_edge = s ^ prev_q;

    // ------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             push_v;
    logic             push_lvl;
    logic [CNT_W-1:0] push_w;
    logic             arm_start;

    assign arm_start = (state == ST_IDLE) && en;

    // Completed records pass through a one-cycle push register before the
    // FIFO write, so a record becomes visible SYNC_STAGES+1 cycles after
    // io_in is sampled. A registered record is still written if en drops
    // in between: the phase it describes was already complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            edge_count <= '0;
            push_v     <= 1'b0;
            push_lvl   <= 1'b0;
            push_w     <= '0;
        end else begin
            push_v <= 1'b0;
            if (!en) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state      <= ST_ARM;
                        edge_count <= '0;
                        cnt        <= CNT_ONE;
                    end
                    ST_ARM: begin
                        // The phase before the first edge is partial: discard.
                        if (io_edge) begin
                            state <= ST_MEASURE;
                            cnt   <= CNT_ONE;
                        end
                    end
                    ST_MEASURE: begin
                        if (io_edge) begin
                            push_v     <= 1'b1;
                            push_lvl   <= prev_q;
                            push_w     <= cnt;
                            edge_count <= edge_count + CNT_ONE;
                            cnt        <= CNT_ONE;
                        end else if (cnt != CNT_MAX) begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Record FIFO (show-ahead)
    // ------------------------------------------------------------------
    logic             mem_lvl [FIFO_DEPTH];
    logic [CNT_W-1:0] mem_w   [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             pop;
    logic             push_ok;
    logic             drop;

    assign full    = (count == LVL_FULL);
    assign m_valid = (count != '0);
    assign pop     = m_valid && m_ready;
    // A pop in the same cycle frees the head slot, so a push into a full
    // FIFO is accepted when it coincides with a pop.
    assign push_ok = push_v && (!full || pop);
    assign drop    = push_v && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + LVL_ONE;
                2'b01:   count <= count - LVL_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_lvl[wr_ptr] <= push_lvl;
            mem_w[wr_ptr]   <= push_w;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (arm_start) begin
            overflow <= 1'b0;
        end
    end

    assign m_level    = m_valid ? mem_lvl[rd_ptr] : 1'b0;
    assign m_width    = m_valid ? mem_w[rd_ptr]   : '0;
    assign fifo_level = count;

endmodule

// File: tb/tb_io_pulse_monitor.sv
// tb_io_pulse_monitor
//   Scoreboard bench for io_pulse_monitor. Stimulus pushes hand-computed
//   {level, width} records into per-instance queues; monitor processes pop
//   and compare whenever a record is accepted (m_valid && m_ready).
//   u_dut uses CNT_W=16, u_dut4 uses CNT_W=4 for saturation and wrap.
module tb_io_pulse_monitor;

    typedef struct {
        logic        lvl;
        logic [15:0] w;
    } rec_t;

    logic        clk;
    logic        rst;
    logic        io_in;
    logic        en;
    logic        m_valid;
    logic        m_ready;
    logic        m_level;
    logic [15:0] m_width;
    logic [15:0] edge_count;
    logic [2:0]  fifo_level;
    logic        overflow;

    logic        io2;
    logic        en2;
    logic        m_valid2;
    logic        m_ready2;
    logic        m_level2;
    logic [3:0]  m_width2;
    logic [3:0]  edge_count2;
    logic [2:0]  fifo_level2;
    logic        overflow2;

    int checks = 0;
    int errors = 0;

    rec_t q1[$];
    rec_t q2[$];

    io_pulse_monitor #(.CNT_W(16), .FIFO_DEPTH(4), .SYNC_STAGES(2)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .io_in      (io_in),
        .en         (en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_level    (m_level),
        .m_width    (m_width),
        .edge_count (edge_count),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    io_pulse_monitor #(.CNT_W(4), .FIFO_DEPTH(4), .SYNC_STAGES(2)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .io_in      (io2),
        .en         (en2),
        .m_valid    (m_valid2),
        .m_ready    (m_ready2),
        .m_level    (m_level2),
        .m_width    (m_width2),
        .edge_count (edge_count2),
        .fifo_level (fifo_level2),
        .overflow   (overflow2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Wait n rising edges, then step 1 time unit past the last one.
    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp1(input logic l, input logic [15:0] w);
        rec_t r;
        r.lvl = l;
        r.w   = w;
        q1.push_back(r);
    endtask

    task automatic exp2(input logic l, input logic [15:0] w);
        rec_t r;
        r.lvl = l;
        r.w   = w;
        q2.push_back(r);
    endtask

    // Monitors: sample on the falling edge, away from state updates.
    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            if (q1.size() == 0) begin
                check("dut16 unexpected record", 32'(m_valid), 32'd0);
            end else begin
                rec_t r;
                r = q1.pop_front();
                check("dut16 m_level", 32'(m_level), 32'(r.lvl));
                check("dut16 m_width", 32'(m_width), 32'(r.w));
            end
        end else if (!m_valid) begin
            check("dut16 empty head", {15'd0, m_level, m_width}, 32'd0);
        end
    end

    always @(negedge clk) begin
        if (m_valid2 && m_ready2) begin
            if (q2.size() == 0) begin
                check("dut4 unexpected record", 32'(m_valid2), 32'd0);
            end else begin
                rec_t r;
                r = q2.pop_front();
                check("dut4 m_level", 32'(m_level2), 32'(r.lvl));
                check("dut4 m_width", 32'(m_width2), 32'(r.w));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        m_ready  = 1'b1;
        io_in    = 1'b0;
        io2      = 1'b0;
        en2      = 1'b0;
        m_ready2 = 1'b1;

        // Reset with io toggling, then idle with en=0.
        for (int i = 0; i < 4; i++) begin
            io_in = ~io_in;
            hold(1);
        end
        check("reset m_valid", 32'(m_valid), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset edge_count", 32'(edge_count), 32'd0);
        check("reset fifo_level", 32'(fifo_level), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            io_in = ~io_in;
            hold(2);
        end
        check("en0 edge_count", 32'(edge_count), 32'd0);
        check("en0 fifo_level", 32'(fifo_level), 32'd0);
        io_in = 1'b0;
        hold(4);

        // Basic sequence: arm, 5 high, 3 low, 7 high, low.
        exp1(1'b1, 16'd5);
        exp1(1'b0, 16'd3);
        exp1(1'b1, 16'd7);
        en = 1'b1;
        hold(3);
        io_in = 1'b1;
        hold(5);
        io_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("latency m_valid low", 32'(m_valid), 32'd0);
        end
        io_in = 1'b1;
        @(posedge clk);
        #1;
        check("latency m_valid high", 32'(m_valid), 32'd1);
        hold(6);
        io_in = 1'b0;
        hold(10);
        check("basic drained", 32'(q1.size()), 32'd0);
        check("basic edge_count", 32'(edge_count), 32'd3);
        check("basic overflow", 32'(overflow), 32'd0);
        check("basic fifo_level", 32'(fifo_level), 32'd0);

        // Overflow: six measured edges into a depth-4 FIFO with no reader.
        en = 1'b0;
        hold(3);
        en = 1'b1;
        m_ready = 1'b0;
        hold(3);
        exp1(1'b1, 16'd2);
        exp1(1'b0, 16'd3);
        exp1(1'b1, 16'd4);
        exp1(1'b0, 16'd5);
        io_in = 1'b1; hold(2);
        io_in = 1'b0; hold(3);
        io_in = 1'b1; hold(4);
        io_in = 1'b0; hold(5);
        io_in = 1'b1; hold(6);
        io_in = 1'b0; hold(7);
        io_in = 1'b1; hold(10);
        check("ovf fifo_level", 32'(fifo_level), 32'd4);
        check("ovf overflow", 32'(overflow), 32'd1);
        check("ovf edge_count", 32'(edge_count), 32'd6);
        m_ready = 1'b1;
        hold(8);
        check("ovf drained", 32'(q1.size()), 32'd0);
        check("ovf fifo_level empty", 32'(fifo_level), 32'd0);
        check("ovf sticky", 32'(overflow), 32'd1);

        // Full FIFO with a pop in the same cycle as the fifth push.
        en = 1'b0;
        hold(3);
        en = 1'b1;
        m_ready = 1'b0;
        hold(3);
        check("rearm overflow clear", 32'(overflow), 32'd0);
        exp1(1'b0, 16'd2);
        exp1(1'b1, 16'd3);
        exp1(1'b0, 16'd4);
        exp1(1'b1, 16'd5);
        exp1(1'b0, 16'd6);
        io_in = 1'b0; hold(2);
        io_in = 1'b1; hold(3);
        io_in = 1'b0; hold(4);
        io_in = 1'b1; hold(5);
        io_in = 1'b0; hold(6);
        io_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("full before pop", 32'(fifo_level), 32'd4);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        check("push+pop fifo_level", 32'(fifo_level), 32'd4);
        check("push+pop overflow", 32'(overflow), 32'd0);
        m_ready = 1'b1;
        hold(8);
        check("push+pop drained", 32'(q1.size()), 32'd0);
        check("push+pop edge_count", 32'(edge_count), 32'd5);
        check("push+pop overflow end", 32'(overflow), 32'd0);

        // CNT_W=4: saturation, 1-cycle pulse, edge_count wrap.
        exp2(1'b1, 16'd15);
        exp2(1'b0, 16'd5);
        exp2(1'b1, 16'd1);
        en2 = 1'b1;
        hold(3);
        io2 = 1'b1; hold(20);
        io2 = 1'b0; hold(5);
        io2 = 1'b1; hold(1);
        io2 = 1'b0; hold(20);
        check("cnt4 edge_count", 32'(edge_count2), 32'd3);
        for (int i = 0; i < 13; i++) begin
            exp2(io2, (i == 0) ? 16'd15 : 16'd2);
            io2 = ~io2;
            hold(2);
        end
        hold(10);
        check("cnt4 edge_count wrap", 32'(edge_count2), 32'd0);
        check("cnt4 drained", 32'(q2.size()), 32'd0);
        check("cnt4 overflow", 32'(overflow2), 32'd0);

        // Reset while measuring with two stored records.
        m_ready = 1'b0;
        io_in = 1'b0; hold(3);
        io_in = 1'b1; hold(6);
        check("pre-rst fifo_level", 32'(fifo_level), 32'd2);
        @(posedge clk);
        #3;
        io_in = 1'b0;
        rst = 1'b1;
        #1;
        check("async rst m_valid", 32'(m_valid), 32'd0);
        check("async rst fifo_level", 32'(fifo_level), 32'd0);
        check("async rst edge_count", 32'(edge_count), 32'd0);
        check("async rst head", {15'd0, m_level, m_width}, 32'd0);
        hold(2);
        rst = 1'b0;
        m_ready = 1'b1;
        hold(4);
        io_in = 1'b1; hold(4);
        hold(4);
        check("post-rst arm fifo_level", 32'(fifo_level), 32'd0);
        check("post-rst arm edge_count", 32'(edge_count), 32'd0);
        exp1(1'b1, 16'd8);
        io_in = 1'b0;
        hold(10);
        check("post-rst edge_count", 32'(edge_count), 32'd1);
        check("post-rst drained", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
